pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Producer side of the forwarding interface: tracks destination-register state of in-flight instructions through the ID/EX, EX/MEM and MEM/WB slots.
- Drives EXM_rd, EXM_RegWrite, MWB_rd and MWB_RegWrite to the forwarding unit.
- Detects load-use hazards, freezes the pipeline on data-memory wait (ready handshake with timeout), and inserts bubbles on branch flush.
- Sits beside the ID stage; its stall outputs gate PC and IF/ID writes.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before entering ERROR; 0 disables the timeout.
- TO_W, 8: wait-counter width; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  5  ID destination
- id_RegWrite, id_MemRead, id_MemWrite  in  1  ID control bits
- flush  in  1  branch taken, resolved in EX
- mem_ready  in  1  data memory completes access this cycle
- IDEX_rd  out  5
- IDEX_RegWrite, IDEX_MemRead  out  1
- EXM_rd  out  5
- EXM_RegWrite  out  1
- MWB_rd  out  5
- MWB_RegWrite  out  1
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- mem_err  out  1  sticky timeout error
- stall_cycles  out  16  performance counter (see Optional Feature)

Behaviour:
- Slots: ID/EX {v, rd, RegWrite, MemRead, MemWrite}; EX/MEM {same}; MEM/WB {v, rd, RegWrite}.
- Slot outputs are registered. rd outputs 0 and RegWrite/MemRead outputs 0 when the slot is invalid.
- Reset (async, rst_n=0): all slots invalid, all outputs 0, state=RUN, wait_cnt=0. Reset mid-wait or in ERROR returns to RUN immediately.
- mem_wait (comb) = state==RUN && EXM.v && (EXM.MemRead | EXM.MemWrite) && !mem_ready.
- load_use (comb) = IDEX.v && IDEX.MemRead && IDEX.rd!=0 && id_valid && ((id_uses_rs1 && id_rs1==IDEX.rd) || (id_uses_rs2 && id_rs2==IDEX.rd)).
- Priority, highest first: ERROR > mem_wait (or state==MEM_WAIT with !mem_ready) > flush > load_use > normal advance.
- ERROR:
  - all slots hold; stall_if=stall_id=1; mem_err=1.
  - MWB_RegWrite forced 0.
  - Exit only by reset.
- Wait condition:
  - ID/EX and EX/MEM hold; MEM/WB loads a bubble (v=0).
  - stall_if=stall_id=1.
  - flush is ignored while waiting. The branch stays in EX and its producer keeps flush asserted.
- flush:
  - ID/EX loads a bubble; EX/MEM<-ID/EX; MEM/WB<-EX/MEM.
  - stall_if=stall_id=0, even if load_use=1.
- load_use: stall_if=stall_id=1; ID/EX loads a bubble; downstream slots advance. Exactly one bubble per hazard.
- Normal: ID/EX <- {id_valid, id_* fields}; EX/MEM <- ID/EX; MEM/WB <- EX/MEM.
- FSM (RUN, MEM_WAIT, ERROR):
  - RUN -> MEM_WAIT when mem_wait; wait_cnt<=1.
  - MEM_WAIT & mem_ready -> RUN; wait_cnt<=0. The slots advance normally in that same cycle.
  - MEM_WAIT & !mem_ready: if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT -> ERROR; else wait_cnt+1.
  - mem_ready on the first access cycle: no wait, no state change.
- Writes with rd==0 propagate unchanged. Filtering x0 is the forwarding unit's job.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined: stall_cycles counts clock cycles with stall_if=1. It saturates at 16'hFFFF and resets to 0.
- Undefined: stall_cycles is tied to 16'h0000, and no counter flops are present.

Test Plan:
- Load x5 in ID/EX (MemRead=1, rd=5); ID add uses rs1=5 -> stall_if=stall_id=1 for 1 cycle. Next cycle IDEX_RegWrite=0 (bubble). Two cycles later the load shows MWB_rd=5, MWB_RegWrite=1 while the add is in ID/EX.
- Load with rd=0 followed by an instruction using rs1=0 -> no stall.
- Store in EX/MEM, mem_ready=0 for 3 cycles then 1 -> stall for 3 cycles; MWB_RegWrite=0 during the wait; EXM_rd held; state returns to RUN; no stall in the release cycle.
- MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 5 wait cycles (4 counts then the ERROR transition); it stays sticky. rst_n pulse low -> all outputs 0, state RUN.
- flush=1 with load_use=1 in the same cycle -> stall_if=0 and ID/EX bubble. flush=1 during a memory wait -> ignored; the flush takes effect in the cycle mem_ready=1.
- PIPE_HAZARD_PERF_EN defined: 3 load-use stalls plus a 3-cycle memory wait -> stall_cycles=6. Undefined -> stall_cycles stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller beside the ID stage: tracks ID/EX, EX/MEM and MEM/WB destination state,
// load-use stalls, data-memory wait with timeout, and flush bubbles. Optional stall counter: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        flush,
    input  logic        mem_ready,
    output logic [4:0]  IDEX_rd,
    output logic        IDEX_RegWrite,
    output logic        IDEX_MemRead,
    output logic [4:0]  EXM_rd,
    output logic        EXM_RegWrite,
    output logic [4:0]  MWB_rd,
    output logic        MWB_RegWrite,
    output logic        stall_if,
    output logic        stall_id,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mw;
    } xslot_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
    } wslot_t;

    xslot_t          idex_q, idex_d;
    xslot_t          exm_q, exm_d;
    wslot_t          mwb_q, mwb_d;
    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_wait;
    logic wait_hold;
    logic load_use;
    logic stall;

    assign mem_wait = (state_q == ST_RUN) && exm_q.v && (exm_q.mr || exm_q.mw) && !mem_ready;
    assign wait_hold = mem_wait || ((state_q == ST_MEM_WAIT) && !mem_ready);

    assign load_use = idex_q.v && idex_q.mr && (idex_q.rd != 5'd0) && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == idex_q.rd)) ||
                       (id_uses_rs2 && (id_rs2 == idex_q.rd)));

    always_comb begin
        idex_d     = idex_q;
        exm_d      = exm_q;
        mwb_d      = mwb_q;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall      = 1'b0;

        if (state_q == ST_ERROR) begin
            stall = 1'b1;
        end else if (wait_hold) begin
            // The branch producer keeps flush high, so ignoring it here loses nothing.
            stall = 1'b1;
            mwb_d = '0;
            if (state_q == ST_RUN) begin
                state_d    = ST_MEM_WAIT;
                wait_cnt_d = TO_W'(1);
            end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_CNT)) begin
                state_d = ST_ERROR;
            end else begin
                wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
        end else begin
            if (state_q == ST_MEM_WAIT) begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
            exm_d = idex_q;
            mwb_d = '{v: exm_q.v, rd: exm_q.rd, rw: exm_q.rw};
            if (flush || load_use) begin
                idex_d = '0;
            end else begin
                idex_d = '{v: id_valid, rd: id_rd, rw: id_RegWrite,
                           mr: id_MemRead, mw: id_MemWrite};
            end
            // A flushed ID instruction is discarded, so holding it would be pointless.
            stall = load_use && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q     <= '0;
            exm_q      <= '0;
            mwb_q      <= '0;
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            idex_q     <= idex_d;
            exm_q      <= exm_d;
            mwb_q      <= mwb_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign IDEX_rd       = idex_q.v ? idex_q.rd : 5'd0;
    assign IDEX_RegWrite = idex_q.v && idex_q.rw;
    assign IDEX_MemRead  = idex_q.v && idex_q.mr;
    assign EXM_rd        = exm_q.v ? exm_q.rd : 5'd0;
    assign EXM_RegWrite  = exm_q.v && exm_q.rw;
    assign MWB_rd        = mwb_q.v ? mwb_q.rd : 5'd0;
    assign MWB_RegWrite  = mwb_q.v && mwb_q.rw && (state_q != ST_ERROR);
    assign stall_if      = stall;
    assign stall_id      = stall;
    assign mem_err       = (state_q == ST_ERROR);

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, x0 loads, memory wait, flush interaction,
// timeout to ERROR and async reset recovery. Expects MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        id_RegWrite, id_MemRead, id_MemWrite;
    logic        flush, mem_ready;
    logic [4:0]  IDEX_rd, EXM_rd, MWB_rd;
    logic        IDEX_RegWrite, IDEX_MemRead, EXM_RegWrite, MWB_RegWrite;
    logic        stall_if, stall_id, mem_err;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int fails   = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .flush(flush), .mem_ready(mem_ready),
        .IDEX_rd(IDEX_rd), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .EXM_rd(EXM_rd), .EXM_RegWrite(EXM_RegWrite),
        .MWB_rd(MWB_rd), .MWB_RegWrite(MWB_RegWrite),
        .stall_if(stall_if), .stall_id(stall_id), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load to ld_rd, then a consumer writing x20; drains the pipe afterwards.
    task automatic lu_pair(input logic [4:0] ld_rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic exp_stall);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ld_rd, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, rs1, u1, rs2, u2, 5'd20, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall_if", stall_if, exp_stall);
        check("lu_stall_id", stall_id, exp_stall);
        tick();
        if (exp_stall) begin
            #1;
            check("lu_bubble", IDEX_RegWrite, 1'b0);
            tick();
        end
        idle();
        #1;
        check("lu_consumer_idex", IDEX_rd, 5'd20);
        tick(); tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        idle();
        #12;
        check("rst_idex_rd", IDEX_rd, 5'd0);
        check("rst_exm_rw", EXM_RegWrite, 1'b0);
        check("rst_mwb_rw", MWB_RegWrite, 1'b0);
        check("rst_stall", stall_if, 1'b0);
        check("rst_err", mem_err, 1'b0);
        check("rst_perf", stall_cycles, 16'd0);
        rst_n = 1'b1;
        tick();

        // Load x5 followed by add using rs1=5
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        check("t1_stall_if", stall_if, 1'b1);
        check("t1_stall_id", stall_id, 1'b1);
        check("t1_idex_rd", IDEX_rd, 5'd5);
        check("t1_idex_mr", IDEX_MemRead, 1'b1);
        tick();
        #1;
        check("t1_bubble_rw", IDEX_RegWrite, 1'b0);
        check("t1_no_restall", stall_if, 1'b0);
        check("t1_exm_rd", EXM_rd, 5'd5);
        check("t1_exm_rw", EXM_RegWrite, 1'b1);
        tick();
        idle();
        #1;
        check("t1_mwb_rd", MWB_rd, 5'd5);
        check("t1_mwb_rw", MWB_RegWrite, 1'b1);
        check("t1_add_idex", IDEX_rd, 5'd6);
        check("t1_add_rw", IDEX_RegWrite, 1'b1);
        tick(); tick(); tick();

        // Load to x0 must not stall; rd=0 still propagates
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("t2_no_stall", stall_if, 1'b0);
        check("t2_idex_mr", IDEX_MemRead, 1'b1);
        tick();
        idle();
        tick(); tick(); tick();

        lu_pair(5'd12, 5'd3, 1'b1, 5'd12, 1'b1, 1'b1);
        lu_pair(5'd12, 5'd12, 1'b0, 5'd1, 1'b1, 1'b0);
        lu_pair(5'd4, 5'd4, 1'b1, 5'd9, 1'b1, 1'b1);

        // Store waits 3 cycles behind an ALU op writing x3
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("t3_w1_stall", stall_if, 1'b1);
        check("t3_w1_mwb_rd", MWB_rd, 5'd3);
        check("t3_w1_mwb_rw", MWB_RegWrite, 1'b1);
        check("t3_w1_exm_rd", EXM_rd, 5'd7);
        tick();
        #1;
        check("t3_w2_stall", stall_id, 1'b1);
        check("t3_w2_mwb_rw", MWB_RegWrite, 1'b0);
        check("t3_w2_exm_rd", EXM_rd, 5'd7);
        check("t3_w2_idex_rd", IDEX_rd, 5'd9);
        tick();
        #1;
        check("t3_w3_stall", stall_if, 1'b1);
        check("t3_w3_exm_rd", EXM_rd, 5'd7);
        tick();
        mem_ready = 1'b1;
        #1;
        check("t3_release_stall", stall_if, 1'b0);
        check("t3_release_exm_rd", EXM_rd, 5'd7);
        tick();
        idle();
        #1;
        check("t3_adv_exm_rd", EXM_rd, 5'd9);
        check("t3_adv_idex_rd", IDEX_rd, 5'd10);
        check("t3_store_mwb_rw", MWB_RegWrite, 1'b0);
        check("t3_no_err", mem_err, 1'b0);
        tick(); tick(); tick();

`ifdef PIPE_HAZARD_PERF_EN
        check("perf_count", stall_cycles, 16'd6);
`else
        check("perf_count", stall_cycles, 16'd0);
`endif

        // flush with load_use in the same cycle
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("t4_flush_stall_if", stall_if, 1'b0);
        check("t4_flush_stall_id", stall_id, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        #1;
        check("t4_bubble_rw", IDEX_RegWrite, 1'b0);
        check("t4_bubble_mr", IDEX_MemRead, 1'b0);
        check("t4_exm_rd", EXM_rd, 5'd8);
        tick(); tick(); tick();

        // flush during a memory wait is deferred to the release cycle
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("t5_w1_stall", stall_if, 1'b1);
        tick();
        #1;
        check("t5_w2_idex_rd", IDEX_rd, 5'd13);
        check("t5_w2_idex_rw", IDEX_RegWrite, 1'b1);
        check("t5_w2_stall", stall_if, 1'b1);
        tick();
        mem_ready = 1'b1;
        #1;
        check("t5_release_stall", stall_if, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        #1;
        check("t5_flush_bubble", IDEX_RegWrite, 1'b0);
        check("t5_exm_rd", EXM_rd, 5'd13);
        check("t5_mwb_rd", MWB_rd, 5'd11);
        check("t5_mwb_rw", MWB_RegWrite, 1'b1);
        tick(); tick(); tick();

        // Timeout: load x15 with memory never ready
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_wait_no_err", mem_err, 1'b0);
            check("t6_wait_stall", stall_if, 1'b1);
            tick();
        end
        #1;
        check("t6_err", mem_err, 1'b1);
        check("t6_err_stall", stall_id, 1'b1);
        check("t6_err_mwb_rw", MWB_RegWrite, 1'b0);
        mem_ready = 1'b1;
        tick();
        #1;
        check("t6_err_sticky", mem_err, 1'b1);
        check("t6_err_exm_rd", EXM_rd, 5'd15);
        rst_n = 1'b0;
        #1;
        check("t6_rst_err", mem_err, 1'b0);
        check("t6_rst_exm_rd", EXM_rd, 5'd0);
        check("t6_rst_exm_rw", EXM_RegWrite, 1'b0);
        check("t6_rst_stall", stall_if, 1'b0);
        check("t6_rst_perf", stall_cycles, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
        #1;
        check("t6_run_stall", stall_if, 1'b0);
        tick();
        idle();
        #1;
        check("t6_run_idex_rd", IDEX_rd, 5'd17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
